// File: rtl/tone_mon_pkg.sv
// Shared types and helpers for the tone period monitor.
package tone_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    CONF = 2'd3
  } lane_state_e;

  // Saturating increment: holds at lim once reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/tone_lane_meas.sv
// One audio lane: debounced neg->pos crossing detection, period/peak measurement,
// limit checks and saturating error counters.
module tone_lane_meas
  import tone_mon_pkg::*;
#(
  parameter int W        = 16,
  parameter int CW       = 12,
  parameter int ECW      = 8,
  parameter int DEBOUNCE = 10,
  parameter int SKIP     = 2
) (
  input  logic           clk,
  input  logic           RST_n,
  input  logic           en,
  input  logic           clr,
  input  logic           smp_vld,
  input  logic [W-1:0]   smp,
  input  logic [CW-1:0]  min_per,
  input  logic [CW-1:0]  max_per,
  input  logic [W-1:0]   min_amp,
  input  logic [W-1:0]   max_amp,
  output logic           res_vld,
  output logic [CW-1:0]  res_period,
  output logic [W-1:0]   res_peak,
  output logic [ECW-1:0] freq_err,
  output logic [ECW-1:0] ampl_err,
  output logic           fail,
  output lane_state_e    state_dbg
);

  localparam int WINW = $clog2(DEBOUNCE + 1);
  localparam int CCW  = $clog2(SKIP + 1);
  localparam logic [CW-1:0]  PER_MAX = '1;
  localparam logic [ECW-1:0] ERR_MAX = '1;

  lane_state_e state, state_next;

  logic                 prev_sign;
  logic [CW-1:0]        per_cnt, cand_per;
  logic signed [W-1:0]  peak, cand_pk;
  logic [WINW-1:0]      win;
  logic [CCW-1:0]       conf_cnt;

  logic                 sign, n2p, p2n;
  logic signed [W-1:0]  smp_s, peak_upd, pk_merged;
  logic [CW-1:0]        per_inc, per_merged;
  logic [CW:0]          merge_sum;
  logic [WINW-1:0]      win_next;
  logic                 do_arm, do_track, do_cross, do_reject, do_confirm, do_eval;
  logic                 per_bad, amp_bad;

  assign smp_s     = smp;
  assign sign      = smp[W-1];
  assign n2p       = prev_sign & ~sign;
  assign p2n       = ~prev_sign & sign;
  assign per_inc   = CW'(sat_inc(32'(per_cnt), 32'(PER_MAX)));
  assign peak_upd  = (smp_s > peak) ? smp_s : peak;
  assign win_next  = win + 1'b1;

  // A rejected candidate folds its partial count back into the running period.
  assign merge_sum  = {1'b0, cand_per} + {1'b0, per_inc};
  assign per_merged = merge_sum[CW] ? PER_MAX : merge_sum[CW-1:0];
  assign pk_merged  = (cand_pk > peak_upd) ? cand_pk : peak_upd;

  assign do_eval = do_confirm && (conf_cnt >= CCW'(SKIP));
  assign per_bad = (cand_per < min_per) || (cand_per > max_per);
  assign amp_bad = (cand_pk < $signed(min_amp)) || (cand_pk > $signed(max_amp));

  assign state_dbg = state;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_next;
  end

  // smp_vld is a one-cycle strobe with no back-pressure; res_vld is a one-cycle pulse
  // in the cycle after the confirming sample.
  always_comb begin
    state_next = state;
    do_arm     = 1'b0;
    do_track   = 1'b0;
    do_cross   = 1'b0;
    do_reject  = 1'b0;
    do_confirm = 1'b0;
    if (clr) begin
      state_next = en ? ARM : IDLE;
    end else if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = ARM;
        ARM: if (smp_vld) begin
          do_arm     = 1'b1;
          state_next = WAIT;
        end
        WAIT: if (smp_vld) begin
          do_track = 1'b1;
          if (n2p) begin
            do_cross   = 1'b1;
            state_next = CONF;
          end
        end
        CONF: if (smp_vld) begin
          do_track = 1'b1;
          if (p2n) begin
            do_reject  = 1'b1;
            state_next = WAIT;
          end else if (win_next == WINW'(DEBOUNCE)) begin
            do_confirm = 1'b1;
            state_next = WAIT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n || clr) begin
      prev_sign  <= 1'b0;
      per_cnt    <= '0;
      cand_per   <= '0;
      peak       <= '0;
      cand_pk    <= '0;
      win        <= '0;
      conf_cnt   <= '0;
      res_vld    <= 1'b0;
      res_period <= '0;
      res_peak   <= '0;
      freq_err   <= '0;
      ampl_err   <= '0;
      fail       <= 1'b0;
    end else begin
      res_vld <= do_eval;
      if (do_arm) begin
        prev_sign <= sign;
        per_cnt   <= '0;
        peak      <= '0;
      end
      if (do_track) begin
        prev_sign <= sign;
        if (do_cross) begin
          cand_per <= per_cnt;
          cand_pk  <= peak;
          per_cnt  <= CW'(1);
          peak     <= smp_s;
          win      <= WINW'(1);
        end else if (do_reject) begin
          per_cnt <= per_merged;
          peak    <= pk_merged;
        end else begin
          per_cnt <= per_inc;
          peak    <= peak_upd;
          if (state == CONF) win <= win_next;
        end
      end
      if (do_confirm) conf_cnt <= CCW'(sat_inc(32'(conf_cnt), 32'(SKIP)));
      if (do_eval) begin
        res_period <= cand_per;
        res_peak   <= cand_pk;
        if (per_bad) freq_err <= ECW'(sat_inc(32'(freq_err), 32'(ERR_MAX)));
        if (amp_bad) ampl_err <= ECW'(sat_inc(32'(ampl_err), 32'(ERR_MAX)));
        fail <= fail | per_bad | amp_bad;
      end
    end
  end

endmodule

// File: rtl/tone_period_monitor.sv
// Multi-channel tone checker: one independent tone_lane_meas per audio lane,
// shared runtime limits, packed per-lane outputs.
module tone_period_monitor
  import tone_mon_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int W        = 16,
  parameter int CW       = 12,
  parameter int ECW      = 8,
  parameter int DEBOUNCE = 10,
  parameter int SKIP     = 2
) (
  input  logic               clk,
  input  logic               RST_n,
  input  logic               en,
  input  logic               clr,
  input  logic               smp_vld,
  input  logic [NCH*W-1:0]   smp_data,
  input  logic [CW-1:0]      min_per,
  input  logic [CW-1:0]      max_per,
  input  logic [W-1:0]       min_amp,
  input  logic [W-1:0]       max_amp,
  output logic [NCH-1:0]     res_vld,
  output logic [NCH*CW-1:0]  res_period,
  output logic [NCH*W-1:0]   res_peak,
  output logic [NCH*ECW-1:0] freq_err,
  output logic [NCH*ECW-1:0] ampl_err,
  output logic [NCH-1:0]     fail,
  output logic [NCH*2-1:0]   dbg_state
);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    lane_state_e st;

    tone_lane_meas #(
      .W        (W),
      .CW       (CW),
      .ECW      (ECW),
      .DEBOUNCE (DEBOUNCE),
      .SKIP     (SKIP)
    ) u_lane (
      .clk        (clk),
      .RST_n      (RST_n),
      .en         (en),
      .clr        (clr),
      .smp_vld    (smp_vld),
      .smp        (smp_data[i*W +: W]),
      .min_per    (min_per),
      .max_per    (max_per),
      .min_amp    (min_amp),
      .max_amp    (max_amp),
      .res_vld    (res_vld[i]),
      .res_period (res_period[i*CW +: CW]),
      .res_peak   (res_peak[i*W +: W]),
      .freq_err   (freq_err[i*ECW +: ECW]),
      .ampl_err   (ampl_err[i*ECW +: ECW]),
      .fail       (fail[i]),
      .state_dbg  (st)
    );

    assign dbg_state[2*i +: 2] = st;
  end

endmodule
